regfile_swc: RTL and testbench

- Integer register file that serves the execute units of the switch MCU core.
- It answers their read requests (reg_raddr_*/reg_ren_* in, reg_rdata_* out) and absorbs their writebacks (reg_waddr/reg_wen/reg_wdata).
- Two registered read ports and one write port, with same-cycle write-to-read forwarding and hardwired x0.
- A post-reset clear sequencer zeroes every entry, so no block-RAM power-up contents are ever visible.

---
 rtl/regfile_swc_pkg.sv | 23 ++
 rtl/regfile_swc_if.sv | 32 +++
 rtl/regfile_swc_rf_clear_seq.sv | 45 ++++
 rtl/regfile_swc.sv | 113 +++++++++++
 tb/tb_regfile_swc.sv | 172 +++++++++++++++++
 5 files changed

// File: rtl/regfile_swc_pkg.sv
// Shared constants and types for the switch-MCU integer register file.
package swc_pkg;

  localparam int XLEN = 32;
  localparam int NREG = 32;
  localparam int AW   = $clog2(NREG);

  // Register x0 is hardwired to zero
  localparam logic [AW-1:0] X0_ADDR = '0;

  typedef enum logic {
    RF_CLEAR,
    RF_READY
  } rf_state_t;

  // Source of a read port's output data
  typedef enum logic [1:0] {
    RD_ZERO,
    RD_MEM,
    RD_FWD
  } rd_sel_t;

endpackage

// File: rtl/regfile_swc_if.sv
// Execute-unit <-> register-file bus: two read ports, one write port, busy flag.
interface regfile_swc_if;
  import swc_pkg::*;

  logic [AW-1:0]   reg_raddr_1;
  logic            reg_ren_1;
  logic [XLEN-1:0] reg_rdata_1;
  logic            reg_rvalid_1;
  logic [AW-1:0]   reg_raddr_2;
  logic            reg_ren_2;
  logic [XLEN-1:0] reg_rdata_2;
  logic            reg_rvalid_2;
  logic [AW-1:0]   reg_waddr;
  logic            reg_wen;
  logic [XLEN-1:0] reg_wdata;
  logic            rf_busy;

  // Execute-unit side
  modport master (
    output reg_raddr_1, reg_ren_1, reg_raddr_2, reg_ren_2,
    output reg_waddr, reg_wen, reg_wdata,
    input  reg_rdata_1, reg_rvalid_1, reg_rdata_2, reg_rvalid_2, rf_busy
  );

  // Register-file side
  modport slave (
    input  reg_raddr_1, reg_ren_1, reg_raddr_2, reg_ren_2,
    input  reg_waddr, reg_wen, reg_wdata,
    output reg_rdata_1, reg_rvalid_1, reg_rdata_2, reg_rvalid_2, rf_busy
  );

endinterface

// File: rtl/regfile_swc_rf_clear_seq.sv
// Post-reset clear sequencer: walks entries 1..NREG-1 writing zero, then
// releases the register file for normal use.
module rf_clear_seq
  import swc_pkg::*;
(
  input  logic          hclk,
  input  logic          hrstn,
  output logic          clr_we,
  output logic [AW-1:0] clr_addr,
  output logic          rf_busy
);

  rf_state_t     r_state;
  rf_state_t     w_state_next;
  logic [AW-1:0] r_clr_idx;

  // State and clear-index registers; reset restarts clearing at entry 1
  always_ff @(posedge hclk) begin
    if (hrstn) begin
      r_state   <= RF_CLEAR;
      r_clr_idx <= AW'(1);
    end else begin
      r_state <= w_state_next;
      if (r_state == RF_CLEAR) begin
        r_clr_idx <= r_clr_idx + 1'b1;
      end
    end
  end

  // Next state: leave CLEAR on the cycle the last entry is zeroed
  always_comb begin
    w_state_next = r_state;
    if ((r_state == RF_CLEAR) && (r_clr_idx == AW'(NREG - 1))) begin
      w_state_next = RF_READY;
    end
  end

  // Outputs: write zero to the current index while clearing
  always_comb begin
    clr_we   = (r_state == RF_CLEAR);
    clr_addr = r_clr_idx;
    rf_busy  = (r_state == RF_CLEAR);
  end

endmodule

// File: rtl/regfile_swc.sv
// Integer register file: 2 registered read ports, 1 write port, same-cycle
// write-to-read forwarding, hardwired x0, and a post-reset clear sequence.
module regfile_swc
  import swc_pkg::*;
(
  input  logic          hclk,
  input  logic          hrstn,
  regfile_swc_if.slave  bus
);

  logic            w_clr_we;
  logic [AW-1:0]   w_clr_addr;
  logic            w_busy;

  logic            w_we;
  logic [AW-1:0]   w_wa;
  logic [XLEN-1:0] w_wd;

  logic [XLEN-1:0] r_mem [NREG];

  logic [AW-1:0]   w_raddr  [2];
  logic            w_ren    [2];
  logic [XLEN-1:0] w_rdata  [2];
  logic            w_rvalid [2];

  rf_clear_seq u_clear_seq (
    .hclk     (hclk),
    .hrstn    (hrstn),
    .clr_we   (w_clr_we),
    .clr_addr (w_clr_addr),
    .rf_busy  (w_busy)
  );

  assign bus.rf_busy = w_busy;

  assign w_raddr[0] = bus.reg_raddr_1;
  assign w_ren[0]   = bus.reg_ren_1;
  assign w_raddr[1] = bus.reg_raddr_2;
  assign w_ren[1]   = bus.reg_ren_2;

  assign bus.reg_rdata_1  = w_rdata[0];
  assign bus.reg_rvalid_1 = w_rvalid[0];
  assign bus.reg_rdata_2  = w_rdata[1];
  assign bus.reg_rvalid_2 = w_rvalid[1];

  // Single write port shared by the clear sequencer and the execute units;
  // x0 is never written by either source.
  always_comb begin
    w_we = 1'b0;
    w_wa = bus.reg_waddr;
    w_wd = bus.reg_wdata;
    if (w_busy) begin
      w_we = w_clr_we;
      w_wa = w_clr_addr;
      w_wd = '0;
    end else if (bus.reg_wen && (bus.reg_waddr != X0_ADDR)) begin
      w_we = 1'b1;
    end
  end

  // Storage array write
  always_ff @(posedge hclk) begin
    if (w_we) begin
      r_mem[w_wa] <= w_wd;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_rd
      logic [XLEN-1:0] r_mem_q;
      logic [XLEN-1:0] r_fwd_q;
      rd_sel_t         r_sel;
      logic            r_valid;
      logic            w_accept;

      assign w_accept = w_ren[gi] && !w_busy;

      // Raw array read, unreset so it maps onto the RAM output register
      always_ff @(posedge hclk) begin
        if (w_accept) begin
          r_mem_q <= r_mem[w_raddr[gi]];
        end
      end

      // Track where this port's data comes from; holds when no request
      always_ff @(posedge hclk) begin
        if (hrstn) begin
          r_sel   <= RD_ZERO;
          r_valid <= 1'b0;
          r_fwd_q <= '0;
        end else begin
          r_valid <= w_accept;
          if (w_accept) begin
            r_fwd_q <= bus.reg_wdata;
            if (w_raddr[gi] == X0_ADDR) begin
              r_sel <= RD_ZERO;
            end else if (bus.reg_wen && (bus.reg_waddr == w_raddr[gi])) begin
              r_sel <= RD_FWD;
            end else begin
              r_sel <= RD_MEM;
            end
          end
        end
      end

      assign w_rdata[gi]  = (r_sel == RD_FWD) ? r_fwd_q :
                            (r_sel == RD_MEM) ? r_mem_q : '0;
      assign w_rvalid[gi] = r_valid;
    end
  endgenerate

endmodule

// File: tb/tb_regfile_swc.sv
// Self-checking bench for regfile_swc: directed scenarios plus randomized
// traffic against an array-based reference model.
module tb_regfile_swc;
  import swc_pkg::*;

  logic hclk;
  logic hrstn;
  int   checks;
  int   failures;

  logic [31:0] model [32];
  logic [31:0] exp_rd [2];
  logic        exp_rv [2];

  regfile_swc_if bus_if ();

  regfile_swc dut (
    .hclk  (hclk),
    .hrstn (hrstn),
    .bus   (bus_if)
  );

  initial begin
    hclk = 1'b0;
    forever #5 hclk = ~hclk;
  end

  task automatic step();
    @(posedge hclk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic wen, input logic [4:0] wa, input logic [31:0] wd,
                       input logic ren1, input logic [4:0] ra1,
                       input logic ren2, input logic [4:0] ra2);
    bus_if.reg_wen     = wen;
    bus_if.reg_waddr   = wa;
    bus_if.reg_wdata   = wd;
    bus_if.reg_ren_1   = ren1;
    bus_if.reg_raddr_1 = ra1;
    bus_if.reg_ren_2   = ren2;
    bus_if.reg_raddr_2 = ra2;
  endtask

  // One READY-state cycle: predict from the model, clock, compare all outputs
  task automatic cycle(input string tag, input logic wen, input logic [4:0] wa,
                       input logic [31:0] wd, input logic ren1, input logic [4:0] ra1,
                       input logic ren2, input logic [4:0] ra2);
    logic       ren;
    logic [4:0] ra;
    drive(wen, wa, wd, ren1, ra1, ren2, ra2);
    for (int p = 0; p < 2; p++) begin
      ren = (p == 0) ? ren1 : ren2;
      ra  = (p == 0) ? ra1 : ra2;
      exp_rv[p] = ren;
      if (ren) begin
        if (ra == 5'd0)               exp_rd[p] = 32'h0;
        else if (wen && (wa == ra))   exp_rd[p] = wd;
        else                          exp_rd[p] = model[ra];
      end
    end
    if (wen && (wa != 5'd0)) model[wa] = wd;
    step();
    $display("txn %s wen=%0d wa=%0d wd=%08h r1=%0d/%0d r2=%0d/%0d -> d1=%08h v1=%0d d2=%08h v2=%0d",
             tag, wen, wa, wd, ren1, ra1, ren2, ra2, bus_if.reg_rdata_1,
             bus_if.reg_rvalid_1, bus_if.reg_rdata_2, bus_if.reg_rvalid_2);
    chk({tag, "_rd1"}, bus_if.reg_rdata_1, exp_rd[0]);
    chk({tag, "_rv1"}, 32'(bus_if.reg_rvalid_1), 32'(exp_rv[0]));
    chk({tag, "_rd2"}, bus_if.reg_rdata_2, exp_rd[1]);
    chk({tag, "_rv2"}, 32'(bus_if.reg_rvalid_2), 32'(exp_rv[1]));
    chk({tag, "_busy"}, 32'(bus_if.rf_busy), 32'd0);
  endtask

  // Apply reset for ncyc edges, then watch the clear phase; a write/read
  // attempt is injected on clear cycle 10 and must have no effect.
  task automatic run_reset(input int ncyc);
    int cnt;
    drive(0, 0, 0, 0, 0, 0, 0);
    hrstn = 1'b1;
    repeat (ncyc) step();
    chk("rst_busy", 32'(bus_if.rf_busy), 32'd1);
    chk("rst_rv1", 32'(bus_if.reg_rvalid_1), 32'd0);
    chk("rst_rv2", 32'(bus_if.reg_rvalid_2), 32'd0);
    chk("rst_rd1", bus_if.reg_rdata_1, 32'h0);
    chk("rst_rd2", bus_if.reg_rdata_2, 32'h0);
    hrstn = 1'b0;
    for (int i = 0; i < 32; i++) model[i] = 32'h0;
    exp_rd[0] = 32'h0; exp_rd[1] = 32'h0;
    exp_rv[0] = 1'b0;  exp_rv[1] = 1'b0;
    cnt = 0;
    while ((bus_if.rf_busy === 1'b1) && (cnt < 100)) begin
      cnt++;
      if (cnt == 10) drive(1, 5'd3, 32'hA5, 1, 5'd3, 1, 5'd3);
      else           drive(0, 0, 0, 0, 0, 0, 0);
      step();
      chk("clr_rv1", 32'(bus_if.reg_rvalid_1), 32'd0);
      chk("clr_rv2", 32'(bus_if.reg_rvalid_2), 32'd0);
      chk("clr_rd1", bus_if.reg_rdata_1, 32'h0);
    end
    drive(0, 0, 0, 0, 0, 0, 0);
    $display("txn clear busy_cycles=%0d", cnt);
    chk("clear_len", 32'(cnt), 32'd31);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    hrstn    = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0);

    // Clear sequence after a 2-cycle reset; every entry reads zero
    run_reset(2);
    for (int a = 0; a < 32; a++) cycle("clr_rd", 0, 0, 0, 1, 5'(a), 1, 5'(31 - a));
    cycle("x3_after_busy", 0, 0, 0, 1, 5'd3, 0, 0);
    chk("x3_zero", bus_if.reg_rdata_1, 32'h0);

    // Write then read, then hold
    cycle("wr_x5", 1, 5'd5, 32'hDEADBEEF, 0, 0, 0, 0);
    cycle("rd_x5", 0, 0, 0, 1, 5'd5, 0, 0);
    chk("x5_val", bus_if.reg_rdata_1, 32'hDEADBEEF);
    chk("x5_valid", 32'(bus_if.reg_rvalid_1), 32'd1);
    cycle("hold_x5", 0, 0, 0, 0, 0, 0, 0);
    chk("x5_hold", bus_if.reg_rdata_1, 32'hDEADBEEF);
    chk("x5_hold_rv", 32'(bus_if.reg_rvalid_1), 32'd0);

    // Forwarding, same and different address
    cycle("wr_x7", 1, 5'd7, 32'h11, 0, 0, 0, 0);
    cycle("wr_x8", 1, 5'd8, 32'h33, 0, 0, 0, 0);
    cycle("fwd_x7", 1, 5'd7, 32'h22, 1, 5'd7, 1, 5'd7);
    chk("fwd_p1", bus_if.reg_rdata_1, 32'h22);
    chk("fwd_p2", bus_if.reg_rdata_2, 32'h22);
    cycle("nofwd_x8", 1, 5'd7, 32'h44, 1, 5'd8, 0, 0);
    chk("nofwd_val", bus_if.reg_rdata_1, 32'h33);

    // x0 is hardwired
    cycle("wr_x0", 1, 5'd0, 32'hFFFFFFFF, 0, 0, 1, 5'd0);
    chk("x0_fwd", bus_if.reg_rdata_2, 32'h0);
    cycle("rd_x0", 0, 0, 0, 1, 5'd0, 1, 5'd0);
    chk("x0_later", bus_if.reg_rdata_1, 32'h0);

    // Randomized traffic, including back-to-back writes and address collisions
    for (int i = 0; i < 300; i++) begin
      logic [4:0] wa, a1, a2;
      wa = (i % 2 == 0) ? 5'($urandom_range(0, 7)) : 5'($urandom_range(0, 31));
      a1 = (i % 3 == 0) ? wa : 5'($urandom_range(0, 7));
      a2 = (i % 5 == 0) ? wa : 5'($urandom_range(0, 31));
      cycle("rnd", 1'($urandom_range(0, 1)), wa, $urandom,
            1'($urandom_range(0, 1)), a1, 1'($urandom_range(0, 1)), a2);
    end

    // Mid-operation reset wipes contents
    cycle("wr_x9", 1, 5'd9, 32'h1234, 0, 0, 0, 0);
    cycle("rd_x9", 0, 0, 0, 1, 5'd9, 0, 0);
    chk("x9_pre", bus_if.reg_rdata_1, 32'h1234);
    run_reset(1);
    cycle("rd_x9_post", 0, 0, 0, 1, 5'd9, 1, 5'd9);
    chk("x9_post", bus_if.reg_rdata_1, 32'h0);
    chk("x9_post_rv", 32'(bus_if.reg_rvalid_2), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
